spmv_result_collector: RTL and testbench

SPMV_RESULT_COLLECTOR -- requirements
Module: spmv_result_collector

---
 rtl/spmv_pkg.sv | 15 +
 rtl/spmv_result_ram.sv | 34 +++
 rtl/spmv_result_collector.sv | 149 ++++++++++++++
 tb/tb_spmv_result_collector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared widths and collector state encoding for the SpMV result collector.
package spmv_pkg;

    localparam int unsigned ROW_W  = 10;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } collector_state_e;

endpackage

// File: rtl/spmv_result_ram.sv
// Row-sum storage: one synchronous write port, one registered read port.
// Contents are never reset; read data is forced to zero for unwritten rows.
module spmv_result_ram
    import spmv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_keep,
    input  logic [ROW_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_keep carries the written bit so stale rows come out as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_en && rd_keep) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/spmv_result_collector.sv
// Accumulates per-row product beats, commits row sums to RAM, serves reads once done.
// Optional saturating accumulation with sticky ovf: define SPMV_COLLECT_SAT_EN.
module spmv_result_collector
    import spmv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_zeros,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic              in_last,
    input  logic              rd_req,
    input  logic [ROW_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    collector_state_e  state, state_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic [ROW_W-1:0]  cur_row, cur_row_nx;
    logic [DEPTH-1:0]  written;
    logic              commit;
    logic              rd_hit;
    logic [DATA_W-1:0] beat_val;
    logic [DATA_W-1:0] acc_val;

`ifdef SPMV_COLLECT_SAT_EN
    logic [DATA_W+1:0] beat_sum;
    logic [DATA_W+1:0] acc_sum;
    logic              beat_ovf;
    logic              acc_ovf;
    logic              ovf_set;

    assign beat_sum = {2'b00, in_op1} + {2'b00, in_op2};
    assign acc_sum  = {2'b00, acc} + beat_sum;
    assign beat_ovf = |beat_sum[DATA_W+1:DATA_W];
    assign acc_ovf  = |acc_sum[DATA_W+1:DATA_W];
    assign beat_val = beat_ovf ? '1 : beat_sum[DATA_W-1:0];
    assign acc_val  = acc_ovf  ? '1 : acc_sum[DATA_W-1:0];

    // Overflow only counts for additions that actually land in acc
    assign ovf_set = in_valid && !in_zeros &&
                     (((state == IDLE) && beat_ovf) ||
                      ((state == ACCUM) && ((in_row == cur_row) ? acc_ovf : beat_ovf)));

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end
`else
    assign beat_val = in_op1 + in_op2;
    assign acc_val  = acc + in_op1 + in_op2;
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            busy     <= (state_nx == ACCUM) || (state_nx == FLUSH);
            done     <= (state_nx == DONE);
            rd_valid <= rd_hit;
        end
    end

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        cur_row_nx = cur_row;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    cur_row_nx = in_row;
                    acc_nx     = in_zeros ? '0 : beat_val;
                    state_nx   = in_last ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (in_row == cur_row) begin
                        if (!in_zeros) begin
                            acc_nx = acc_val;
                        end
                    end else begin
                        commit     = 1'b1;
                        cur_row_nx = in_row;
                        acc_nx     = in_zeros ? '0 : beat_val;
                    end
                    if (in_last) begin
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                commit   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cur_row <= '0;
            written <= '0;
        end else begin
            acc     <= acc_nx;
            cur_row <= cur_row_nx;
            if (commit) begin
                written[cur_row] <= 1'b1;
            end
        end
    end

    assign rd_hit = rd_req && (state == DONE);

    // Commits are suppressed while reset is high so an abandoned row never lands
    spmv_result_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit && !reset),
        .wr_addr (cur_row),
        .wr_data (acc),
        .rd_en   (rd_hit),
        .rd_keep (written[rd_addr]),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_spmv_result_collector.sv
// Self-checking bench for spmv_result_collector: directed scenarios plus a
// small randomized run, with a read-result scoreboard.
module tb_spmv_result_collector;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_zeros;
    logic [9:0]  in_row;
    logic [63:0] in_op1;
    logic [63:0] in_op2;
    logic        in_last;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        ovf;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb [$];

    spmv_result_collector dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_zeros (in_zeros),
        .in_row   (in_row),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .in_last  (in_last),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Read results are compared against the scoreboard in request order
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_spurious", 64'(rd_valid), 64'd0);
            end else begin
                check("rd_data", rd_data, sb.pop_front());
            end
        end
    end

    task automatic drive_idle();
        in_valid = 1'b0;
        in_zeros = 1'b0;
        in_last  = 1'b0;
        in_row   = '0;
        in_op1   = '0;
        in_op2   = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
    endtask

    task automatic beat(input int row, input logic [63:0] a, input logic [63:0] b,
                        input bit z, input bit l);
        in_valid = 1'b1;
        in_row   = 10'(row);
        in_op1   = a;
        in_op2   = b;
        in_zeros = z;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic rd(input int row, input logic [63:0] exp);
        rd_req  = 1'b1;
        rd_addr = 10'(row);
        sb.push_back(exp);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [63:0] m_val [16];
    bit          m_wr  [16];

    initial begin
        reset = 1'b1;
        drive_idle();

        // Single row accumulating three beats
        do_reset();
        beat(3, 64'd1, 64'd2, 1'b0, 1'b0);
        check("busy_accum", 64'(busy), 64'd1);
        beat(3, 64'd3, 64'd4, 1'b0, 1'b0);
        beat(3, 64'd5, 64'd0, 1'b0, 1'b1);
        drive_idle();
        wait_done();
        rd(3, 64'd15);
        drain();

        // Row changes, back-to-back beats, unwritten and stale rows
        do_reset();
        beat(0, 64'd10, 64'd0, 1'b0, 1'b0);
        beat(0, 64'd10, 64'd0, 1'b0, 1'b0);
        beat(1, 64'd10, 64'd0, 1'b0, 1'b0);
        beat(2, 64'd10, 64'd0, 1'b0, 1'b1);
        drive_idle();
        wait_done();
        rd(0, 64'd20);
        rd(1, 64'd10);
        rd(2, 64'd10);
        rd(5, 64'd0);
        rd(3, 64'd0);
        drain();

        // Zeros beat overrides operands and still commits
        do_reset();
        beat(7, 64'd99, 64'd0, 1'b1, 1'b1);
        drive_idle();
        wait_done();
        rd(7, 64'd0);
        drain();

        // Carry out of bit 63
        do_reset();
        beat(4, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
        beat(4, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1);
        drive_idle();
        wait_done();
`ifdef SPMV_COLLECT_SAT_EN
        rd(4, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ovf", 64'(ovf), 64'd1);
`else
        rd(4, 64'd0);
        check("ovf", 64'(ovf), 64'd0);
`endif
        drain();

        // Decreasing row index and overwrite of an earlier commit
        do_reset();
        beat(5, 64'd1, 64'd0, 1'b0, 1'b0);
        beat(2, 64'd2, 64'd0, 1'b0, 1'b0);
        beat(5, 64'd4, 64'd0, 1'b0, 1'b1);
        drive_idle();
        wait_done();
        rd(5, 64'd4);
        rd(2, 64'd2);
        drain();

        // Read during ACCUM, then reset mid-ACCUM after row 2 committed
        do_reset();
        beat(2, 64'd5, 64'd0, 1'b0, 1'b0);
        rd_req  = 1'b1;
        rd_addr = 10'd2;
        beat(3, 64'd6, 64'd0, 1'b0, 1'b0);
        check("rd_valid_accum", 64'(rd_valid), 64'd0);
        rd_req = 1'b0;
        do_reset();
        beat(9, 64'd1, 64'd1, 1'b0, 1'b1);
        drive_idle();
        wait_done();
        rd(2, 64'd0);
        rd(3, 64'd0);
        rd(9, 64'd2);

        // Beats while DONE are ignored
        beat(9, 64'd100, 64'd0, 1'b0, 1'b1);
        beat(1, 64'd7, 64'd0, 1'b0, 1'b0);
        drive_idle();
        @(negedge clk);
        check("done_hold", 64'(done), 64'd1);
        check("busy_hold", 64'(busy), 64'd0);
        rd(9, 64'd2);
        rd(1, 64'd0);
        drain();

        // Randomized run against a row-sum model
        do_reset();
        for (int r = 0; r < 16; r++) begin
            m_val[r] = '0;
            m_wr[r]  = 1'b0;
        end
        begin
            int          cur;
            int          row;
            logic [63:0] acc;
            logic [63:0] a;
            logic [63:0] b;
            bit          z;
            cur = 0;
            acc = '0;
            for (int i = 0; i < 24; i++) begin
                row = (i > 0 && $urandom_range(0, 1) == 1) ? cur : int'($urandom_range(0, 15));
                a   = 64'($urandom);
                b   = 64'($urandom);
                z   = ($urandom_range(0, 7) == 0);
                if (i == 0) begin
                    cur = row;
                    acc = z ? 64'd0 : a + b;
                end else if (row == cur) begin
                    if (!z) acc = acc + a + b;
                end else begin
                    m_val[cur] = acc;
                    m_wr[cur]  = 1'b1;
                    cur        = row;
                    acc        = z ? 64'd0 : a + b;
                end
                beat(row, a, b, z, i == 23);
            end
            m_val[cur] = acc;
            m_wr[cur]  = 1'b1;
        end
        drive_idle();
        wait_done();
        for (int r = 0; r < 16; r++) begin
            rd(r, m_wr[r] ? m_val[r] : 64'd0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
